// File: rtl/mem_access_unit.sv
// Byte-serialising load/store sequencer for the 4-bank byte memory; 8/16-bit requests, little-endian.
// Optional misaligned-word rejection when MEM_ALIGN_CHECK_EN is defined.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | strobe at A (low byte)
// ACC1  | strobe at A+1 (high byte); word loads capture the low byte
// CAP   | no strobe; capture the final read byte
// RESP  | one-cycle response pulse
module mem_access_unit #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_word,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;

    state_t            state, state_nx;
    logic              we_q, word_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        lo_q;
    logic              accept;
    logic              mis_q, mis_req;
    logic              nx_we, nx_re;
    logic [ADDR_W-1:0] nx_addr;
    logic [7:0]        nx_wdata;

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_q   = word_q & addr_q[0];
    assign mis_req = req_word & req_addr[0];
`else
    assign mis_q   = 1'b0;
    assign mis_req = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = ACC0;
            ACC0: begin
                if (mis_q)       state_nx = RESP;
                else if (word_q) state_nx = ACC1;
                else if (we_q)   state_nx = RESP;
                else             state_nx = CAP;
            end
            ACC1:    state_nx = we_q ? RESP : CAP;
            CAP:     state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are registered, so they are derived for the state being entered.
    // On entry to ACC0 the request is being latched this edge, so use req_* directly.
    always_comb begin
        nx_we    = 1'b0;
        nx_re    = 1'b0;
        nx_addr  = mem_addr;
        nx_wdata = mem_wdata;
        if (state == IDLE && accept && !mis_req) begin
            nx_we    = req_we;
            nx_re    = !req_we;
            nx_addr  = req_addr;
            nx_wdata = req_we ? req_wdata[7:0] : mem_wdata;
        end else if (state == ACC0 && state_nx == ACC1) begin
            nx_we    = we_q;
            nx_re    = !we_q;
            nx_addr  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            nx_wdata = we_q ? wdata_q[15:8] : mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            word_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lo_q      <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            mem_we    <= nx_we;
            mem_re    <= nx_re;
            mem_addr  <= nx_addr;
            mem_wdata <= nx_wdata;
            rsp_valid <= (state_nx == RESP);
            rsp_err   <= (state == ACC0) && mis_q;
            if (accept) begin
                we_q    <= req_we;
                word_q  <= req_word;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == ACC1 && !we_q)
                lo_q <= mem_rdata;
            if (state == CAP)
                rsp_rdata <= word_q ? {mem_rdata, lo_q} : {8'h00, mem_rdata};
            if (state == ACC0 && mis_q)
                rsp_rdata <= 16'h0000;
        end
    end

endmodule
